obj_attr_fetch_unit: RTL and testbench
======================================

# obj_attr_fetch_unit

- Fetches object attribute halfwords from OAM for a run of consecutive object slots.
- Presents each object's attributes as one packed word on a valid/ready stream.
- Parametrised in attribute count, slot stride and OAM read latency; supports run length, index wrap-around, backpressure and abort.
- Sits between the OAM read port and the object renderer; it is the multi-object successor to the single-object attribute lookup in the object pipeline.

## Interface
Parameters:
- OBJ_W, 7: object index width (128 slots).
- N_ATTR, 3: halfwords fetched per object (1..4). Packed attribute k occupies attr_data[16k+15:16k].
- STRIDE, 4: halfwords per OAM slot (power of two, ≥ N_ATTR).
- READ_LAT, 1: OAM read latency in cycles (1..2).
- Derived localparam ADDR_W = OBJ_W + $clog2(STRIDE).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately.
- start  in  1  begin a run; sampled only in IDLE.
- base_obj  in  OBJ_W  first object index, captured on start.
- obj_count  in  OBJ_W+1  number of slots to visit, captured on start.
- abort  in  1  terminate the run.
- oam_rd  out  1  OAM read strobe.
- oam_addr  out  ADDR_W  halfword address, = obj*STRIDE + k.
- oam_rdata  in  16  read data, valid READ_LAT cycles after the oam_rd cycle.
- attr_valid  out  1  packed attributes available.
- attr_ready  in  1  consumer accepts.
- attr_data  out  16*N_ATTR  packed attributes.
- attr_obj  out  OBJ_W  index of the presented object.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a normal run.

## Operation
- States:
  - IDLE: on start, go to ISSUE if obj_count ≠ 0, else FINISH.
  - ISSUE: N_ATTR cycles with oam_rd=1 and k = 0..N_ATTR-1.
  - WAIT: READ_LAT cycles, draining returned data.
  - PRESENT: attr_valid=1 until attr_ready.
  - FINISH: done=1, then IDLE.
- Capture: a 2-bit return counter writes oam_rdata into slot k when the matching read returns.
- After PRESENT handshake:
  - decrement remaining count;
  - next object = (obj+1) mod 2^OBJ_W;
  - go to ISSUE if remaining count ≠ 0, else FINISH.
- Reads for the next object never overlap presentation of the current one.
- attr_data and attr_obj are stable while attr_valid=1 and attr_ready=0.
- start while busy is ignored. base_obj and obj_count changes after capture have no effect.
- abort in any non-IDLE state:
  - go to IDLE next edge;
  - attr_valid drops;
  - in-flight return data is discarded;
  - done is not pulsed;
  - abort has priority over a simultaneous handshake.
- oam_addr holds its last value when oam_rd=0.

## Timing
- Reset values of all outputs: 0.
- start accepted at edge 0:
  - oam_rd in cycles 1..N_ATTR;
  - last data valid in cycle N_ATTR+READ_LAT;
  - attr_valid from cycle N_ATTR+READ_LAT+1.
  - Defaults: attr_valid in cycle 5.
- Handshake completes on an edge where attr_valid & attr_ready.
  - Next ISSUE begins the following cycle, or done pulses the following cycle.
- obj_count=0: done pulses in cycle 1, busy high cycle 1 only, no oam_rd.
- Reset deassertion mid-run restarts in IDLE. No partial output.

## Configuration
- OBJ_SKIP_DISABLED_EN defined:
  - after capture, an object with attr0[9:8]==2'b10 (not affine, disabled) bypasses PRESENT;
  - it counts toward obj_count;
  - the block proceeds directly to next ISSUE or FINISH.
- Undefined: every object is presented regardless of attr0.

## Structure
- Package obj_fetch_pkg holds:
  - state enum;
  - ATTR0_MODE_LSB/MSB and the DISABLED mode constant;
  - halfword width constant.
- Address, count and capture registers reuse the existing obj_register sub-module. No other sub-module.

## Test plan
- Single object, defaults: base_obj=5, count=1, halfwords 20/21/22 = 0x1234/0x5678/0x9ABC, ready=1.
  - oam_addr 20,21,22 in cycles 1–3; attr_valid cycle 5; attr_data=0x9ABC_5678_1234, attr_obj=5; done cycle 6.
- Backpressure: same stimulus, ready low for 4 cycles.
  - attr_data stable; no oam_rd; done in cycle 10.
- Wrap: base_obj=127, count=2.
  - addresses 508–510 then 0–2; attr_obj 127 then 0; single done.
- Zero length: count=0.
  - done in cycle 1; no oam_rd or attr_valid. start while busy during a 3-object run is ignored.
- Skip: object 2 attr0=0x0200, base=1, count=3.
  - with OBJ_SKIP_DISABLED_EN: attr_obj 1,3;
  - without: attr_obj 1,2,3.
- Abort/reset: abort in cycle 2, so IDLE in cycle 3 with no done. Separately, reset=0 in cycle 4 forces all outputs to 0 immediately.

Source files
------------

// File: rtl/obj_fetch_pkg.sv
// Shared types and constants for the object attribute fetch unit.
// Holds the fetch FSM state enum, halfword width and attr0 mode field.
package obj_fetch_pkg;

    localparam int HW_W = 16;

    // attr0[9:8] is the object mode; 2'b10 means "not affine, disabled"
    localparam int ATTR0_MODE_LSB = 8;
    localparam int ATTR0_MODE_MSB = 9;
    localparam logic [1:0] MODE_DISABLED = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } fetch_state_e;

endpackage

// File: rtl/obj_register.sv
// Enabled storage register with asynchronous active-low clear.
// Ports: clock, reset, en (load), d (next value), q (held value).
module obj_register #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/obj_attr_fetch_unit.sv
// Fetches N_ATTR OAM halfwords per object for a run of consecutive slots
// and presents them packed on a valid/ready stream (attr_*), with abort.
// Ports: clock/reset, start/base_obj/obj_count, abort, oam_rd/oam_addr/
// oam_rdata, attr_valid/attr_ready/attr_data/attr_obj, busy, done.
// Optional: define OBJ_SKIP_DISABLED_EN to skip objects whose attr0 mode
// field reads as disabled.
module obj_attr_fetch_unit
    import obj_fetch_pkg::*;
#(
    parameter int OBJ_W    = 7,
    parameter int N_ATTR   = 3,
    parameter int STRIDE   = 4,
    parameter int READ_LAT = 1,
    localparam int ADDR_W  = OBJ_W + $clog2(STRIDE)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [OBJ_W-1:0]       base_obj,
    input  logic [OBJ_W:0]         obj_count,
    input  logic                   abort,
    output logic                   oam_rd,
    output logic [ADDR_W-1:0]      oam_addr,
    input  logic [HW_W-1:0]        oam_rdata,
    output logic                   attr_valid,
    input  logic                   attr_ready,
    output logic [HW_W*N_ATTR-1:0] attr_data,
    output logic [OBJ_W-1:0]       attr_obj,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W   = OBJ_W + 1;
    localparam int DATA_W  = HW_W * N_ATTR;
    localparam int SLOT_SH = $clog2(STRIDE);

    fetch_state_e state_q;

    logic [1:0]          iss_q;
    logic [1:0]          ret_q;
    logic [READ_LAT-1:0] pipe_q;
    logic                oam_rd_q;
    logic                attr_valid_q;
    logic                done_q;
    logic                busy_q;

    logic [OBJ_W-1:0]  obj_q, obj_d, obj_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              obj_en, cnt_en, addr_en, cap_en;

    logic kill, start_go, hs, ret_vld;
    logic last_iss, last_ret, skip, adv, more;

    function automatic logic [ADDR_W-1:0] slot_addr(
        input logic [OBJ_W-1:0] o,
        input logic [1:0]       k
    );
        return (ADDR_W'(o) << SLOT_SH) | ADDR_W'(k);
    endfunction

    // Return slot capture: the return counter steers each halfword
    always_comb begin
        cap_d = cap_q;
        if (ret_vld) begin
            for (int k = 0; k < N_ATTR; k++) begin
                if (ret_q == 2'(k)) begin
                    cap_d[HW_W*k +: HW_W] = oam_rdata;
                end
            end
        end
    end

    always_comb begin
        kill     = abort && (state_q != S_IDLE);
        start_go = (state_q == S_IDLE) && start;
        ret_vld  = pipe_q[READ_LAT-1];
        last_iss = (iss_q == 2'(N_ATTR-1));
        last_ret = ret_vld && (ret_q == 2'(N_ATTR-1));
        hs       = (state_q == S_PRESENT) && attr_ready && !kill;
`ifdef OBJ_SKIP_DISABLED_EN
        skip     = (state_q == S_WAIT) && last_ret && !kill &&
                   (cap_d[ATTR0_MODE_MSB:ATTR0_MODE_LSB] == MODE_DISABLED);
`else
        skip     = 1'b0;
`endif
        adv      = hs || skip;
        more     = (cnt_q != CNT_W'(1));
        obj_nxt  = obj_q + OBJ_W'(1);

        obj_en   = start_go || adv;
        obj_d    = start_go ? base_obj : obj_nxt;
        cnt_en   = start_go || adv;
        cnt_d    = start_go ? obj_count : cnt_q - CNT_W'(1);

        // Address only moves when a read is about to be issued
        addr_en  = (start_go && (obj_count != '0)) ||
                   (adv && more) ||
                   ((state_q == S_ISSUE) && !last_iss && !kill);
        if (start_go) begin
            addr_d = slot_addr(base_obj, 2'd0);
        end else if (adv) begin
            addr_d = slot_addr(obj_nxt, 2'd0);
        end else begin
            addr_d = slot_addr(obj_q, iss_q + 2'd1);
        end

        cap_en   = ret_vld && !kill;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            iss_q        <= '0;
            ret_q        <= '0;
            pipe_q       <= '0;
            oam_rd_q     <= 1'b0;
            attr_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // In-flight returns are flushed on abort
            pipe_q <= kill ? '0 : READ_LAT'({pipe_q, oam_rd_q});
            if (ret_vld) begin
                ret_q <= ret_q + 2'd1;
            end
            if (kill) begin
                state_q      <= S_IDLE;
                oam_rd_q     <= 1'b0;
                attr_valid_q <= 1'b0;
                busy_q       <= 1'b0;
                ret_q        <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            busy_q <= 1'b1;
                            if (obj_count != '0) begin
                                state_q  <= S_ISSUE;
                                oam_rd_q <= 1'b1;
                                iss_q    <= '0;
                                ret_q    <= '0;
                            end else begin
                                state_q <= S_FINISH;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (last_iss) begin
                            oam_rd_q <= 1'b0;
                            state_q  <= S_WAIT;
                        end else begin
                            iss_q <= iss_q + 2'd1;
                        end
                    end
                    S_WAIT: begin
                        if (last_ret) begin
                            if (skip) begin
                                if (more) begin
                                    state_q  <= S_ISSUE;
                                    oam_rd_q <= 1'b1;
                                    iss_q    <= '0;
                                    ret_q    <= '0;
                                end else begin
                                    state_q <= S_FINISH;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                state_q      <= S_PRESENT;
                                attr_valid_q <= 1'b1;
                            end
                        end
                    end
                    S_PRESENT: begin
                        if (attr_ready) begin
                            attr_valid_q <= 1'b0;
                            if (more) begin
                                state_q  <= S_ISSUE;
                                oam_rd_q <= 1'b1;
                                iss_q    <= '0;
                                ret_q    <= '0;
                            end else begin
                                state_q <= S_FINISH;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    obj_register #(.W(OBJ_W)) u_obj (
        .clock (clock),
        .reset (reset),
        .en    (obj_en),
        .d     (obj_d),
        .q     (obj_q)
    );

    obj_register #(.W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .en    (cnt_en),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    obj_register #(.W(ADDR_W)) u_addr (
        .clock (clock),
        .reset (reset),
        .en    (addr_en),
        .d     (addr_d),
        .q     (addr_q)
    );

    obj_register #(.W(DATA_W)) u_cap (
        .clock (clock),
        .reset (reset),
        .en    (cap_en),
        .d     (cap_d),
        .q     (cap_q)
    );

    assign oam_rd     = oam_rd_q;
    assign oam_addr   = addr_q;
    assign attr_valid = attr_valid_q;
    assign attr_data  = cap_q;
    assign attr_obj   = obj_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_obj_attr_fetch_unit.sv
// Scoreboard bench for obj_attr_fetch_unit with default parameters.
// An OAM model answers reads one cycle later; results are popped on handshake.
module tb_obj_attr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        attr_ready = 1'b0;
    logic [6:0]  base_obj = '0;
    logic [7:0]  obj_count = '0;
    logic [15:0] oam_rdata = '0;
    logic        oam_rd;
    logic [8:0]  oam_addr;
    logic        attr_valid;
    logic [47:0] attr_data;
    logic [6:0]  attr_obj;
    logic        busy;
    logic        done;

    logic [15:0] mem [512];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    bit mon_en = 1'b0;

    logic [54:0] exp_q [$];
    logic [8:0]  rd_addr [$];
    int          rd_cyc [$];
    int done_n, done_cyc, busy_n, first_valid, hs_n, exp_n;

    obj_attr_fetch_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_obj   (base_obj),
        .obj_count  (obj_count),
        .abort      (abort),
        .oam_rd     (oam_rd),
        .oam_addr   (oam_addr),
        .oam_rdata  (oam_rdata),
        .attr_valid (attr_valid),
        .attr_ready (attr_ready),
        .attr_data  (attr_data),
        .attr_obj   (attr_obj),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // OAM model, one-cycle read latency
    always @(posedge clock) begin
        if (oam_rd) oam_rdata <= mem[oam_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [54:0] exp_of(input logic [6:0] o);
        logic [8:0] a;
        a = {o, 2'b00};
        return {o, mem[a + 9'd2], mem[a + 9'd1], mem[a]};
    endfunction

    function automatic bit skipped(input logic [6:0] o);
        logic [15:0] a0;
        a0 = mem[{o, 2'b00}];
`ifdef OBJ_SKIP_DISABLED_EN
        return a0[9:8] == 2'b10;
`else
        return (a0 == 16'hxxxx) && 1'b0;
`endif
    endfunction

    always @(negedge clock) begin
        int rel;
        if (mon_en) begin
            rel = cyc - t0 + 1;
            if (busy) busy_n++;
            if (oam_rd) begin
                rd_addr.push_back(oam_addr);
                rd_cyc.push_back(rel);
            end
            if (done) begin
                done_n++;
                done_cyc = rel;
            end
            if (attr_valid) begin
                if (first_valid < 0) first_valid = rel;
                if (exp_q.size() == 0) begin
                    chk("unexp_valid", {63'd0, attr_valid}, 64'd0);
                end else begin
                    chk("attr_data", attr_data, exp_q[0][47:0]);
                    chk("attr_obj", attr_obj, exp_q[0][54:48]);
                    if (attr_ready) begin
                        void'(exp_q.pop_front());
                        hs_n++;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        mon_en = 1'b0;
        exp_q.delete();
        rd_addr.delete();
        rd_cyc.delete();
        done_n = 0;
        done_cyc = -1;
        busy_n = 0;
        first_valid = -1;
        hs_n = 0;
    endtask

    // Returns #1 after edge 0, i.e. inside cycle 1
    task automatic start_run(input logic [6:0] b, input logic [7:0] n);
        logic [6:0] o;
        clear_logs();
        for (int i = 0; i < int'(n); i++) begin
            o = b + 7'(i);
            if (!skipped(o)) exp_q.push_back(exp_of(o));
        end
        exp_n = exp_q.size();
        @(posedge clock);
        #1;
        start = 1'b1;
        base_obj = b;
        obj_count = n;
        @(posedge clock);
        #1;
        start = 1'b0;
        base_obj = ~b;
        obj_count = 8'd77;
        t0 = cyc;
        mon_en = 1'b1;
    endtask

    task automatic wait_done(input int max);
        for (int k = 0; k < max; k++) begin
            @(negedge clock);
            if (done_n != 0) break;
        end
        @(posedge clock);
        #1;
        chk("done_n", done_n, 1);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_oam_rd"}, oam_rd, 0);
        chk({tag, "_oam_addr"}, oam_addr, 0);
        chk({tag, "_attr_valid"}, attr_valid, 0);
        chk({tag, "_attr_data"}, attr_data, 0);
        chk({tag, "_attr_obj"}, attr_obj, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int wexp [6];
        for (int i = 0; i < 512; i++) mem[i] = 16'hC000 | 16'(i);

        settle(3);
        chk_zero("rst");
        reset = 1'b1;
        settle(2);

        // single object
        mem[20] = 16'h1234;
        mem[21] = 16'h5678;
        mem[22] = 16'h9ABC;
        attr_ready = 1'b1;
        start_run(7'd5, 8'd1);
        chk("exp_word", exp_q[0], {7'd5, 48'h9ABC_5678_1234});
        wait_done(40);
        chk("single_done_cyc", done_cyc, 6);
        chk("single_valid_cyc", first_valid, 5);
        chk("single_rd_n", rd_addr.size(), 3);
        if (rd_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("single_addr", rd_addr[i], 9'(20 + i));
                chk("single_rd_cyc", rd_cyc[i], i + 1);
            end
        end

        // backpressure: ready low cycles 1..8, high from cycle 9
        attr_ready = 1'b0;
        start_run(7'd5, 8'd1);
        repeat (8) @(posedge clock);
        #1;
        attr_ready = 1'b1;
        wait_done(40);
        chk("bp_done_cyc", done_cyc, 10);
        chk("bp_valid_cyc", first_valid, 5);
        chk("bp_rd_n", rd_addr.size(), 3);

        // wrap from slot 127 to slot 0
        mem[508] = 16'h1111;
        mem[509] = 16'h2222;
        mem[510] = 16'h3333;
        mem[0] = 16'h4444;
        mem[1] = 16'h5555;
        mem[2] = 16'h6666;
        wexp = '{508, 509, 510, 0, 1, 2};
        start_run(7'd127, 8'd2);
        wait_done(60);
        chk("wrap_rd_n", rd_addr.size(), 6);
        if (rd_addr.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("wrap_addr", rd_addr[i], wexp[i]);
        end
        chk("wrap_hs_n", hs_n, 2);

        // zero length
        start_run(7'd9, 8'd0);
        wait_done(10);
        settle(3);
        chk("zero_done_cyc", done_cyc, 1);
        chk("zero_busy_n", busy_n, 1);
        chk("zero_rd_n", rd_addr.size(), 0);
        chk("zero_valid", first_valid, -1);

        // start while busy is ignored
        start_run(7'd10, 8'd3);
        @(posedge clock);
        #1;
        start = 1'b1;
        base_obj = 7'd50;
        obj_count = 8'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(100);
        settle(5);
        chk("sbusy_rd_n", rd_addr.size(), 9);
        chk("sbusy_hs_n", hs_n, 3);
        chk("sbusy_idle", busy, 0);
        chk("sbusy_done_n", done_n, 1);

        // disabled-mode object
        mem[4] = 16'h0011;
        mem[8] = 16'h0200;
        mem[12] = 16'h0033;
        start_run(7'd1, 8'd3);
        wait_done(100);
        chk("skip_hs_n", hs_n, exp_n);
`ifdef OBJ_SKIP_DISABLED_EN
        chk("skip_exp_n", exp_n, 2);
`else
        chk("skip_exp_n", exp_n, 3);
`endif
        chk("skip_rd_n", rd_addr.size(), 9);

        // abort in cycle 2
        start_run(7'd5, 8'd1);
        @(posedge clock);
        #1;
        abort = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd", oam_rd, 0);
        chk("abort_valid", attr_valid, 0);
        settle(10);
        chk("abort_done_n", done_n, 0);
        chk("abort_valid_seen", first_valid, -1);
        chk("abort_rd_n", rd_addr.size(), 2);

        start_run(7'd5, 8'd1);
        wait_done(40);
        chk("post_abort_done_cyc", done_cyc, 6);

        // reset in cycle 4
        start_run(7'd5, 8'd3);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk_zero("mid_rst");
        settle(2);
        reset = 1'b1;
        settle(10);
        chk("mid_rst_valid", first_valid, -1);
        chk("mid_rst_done_n", done_n, 0);

        start_run(7'd5, 8'd1);
        wait_done(40);
        chk("post_rst_done_cyc", done_cyc, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
